sha256_stream: RTL and testbench

//  Parametrised SHA-256/SHA-224 compression engine for multi-block messages. Accepts pre-padded
//  512-bit chunks over a valid/ready handshake and carries chaining state H0..H7 across chunks.

---
 rtl/sha256_stream.sv | 184 ++++++++++++++++++
 tb/tb_sha256_stream.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream.sv
// SHA-256/SHA-224 compression engine for pre-padded 512-bit chunks with chaining across blocks.
// Computes ROUNDS_PER_CYCLE rounds per clock and holds the final digest until it is acknowledged.
module sha256_stream #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit ENABLE_224       = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ChunkValid,
    output logic         ChunkReady,
    input  logic [511:0] Chunk,
    input  logic         ChunkFirst,
    input  logic         ChunkLast,
    input  logic         Mode224,
    output logic         DigestValid,
    input  logic         DigestAck,
    output logic [255:0] Digest,
    output logic         Busy
);
    typedef enum logic [1:0] {S_IDLE, S_HASH, S_FINAL, S_DONE} state_t;

    localparam logic [6:0] STEP     = 7'(ROUNDS_PER_CYCLE);
    localparam logic [6:0] LAST_CNT = 7'(64 - ROUNDS_PER_CYCLE);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t        r_state, w_next;
    logic [6:0]    r_cnt;
    logic [31:0]   r_w [16];
    logic [31:0]   r_wk [8];
    logic [31:0]   r_h [8];
    logic          r_mode, r_last, r_chain_valid, r_digest_valid;
    logic [255:0]  r_digest;

    logic          w_accept, w_new_msg, w_mode_in;
    logic [31:0]   w_iv [8];
    logic [31:0]   w_sum [8];
    logic [31:0]   w_w_next [16];
    logic [31:0]   w_wk_next [8];
    logic [31:0]   w_t1, w_t2, w_sched;
    logic [5:0]    w_kidx;
    logic [255:0]  w_digest;

    assign ChunkReady  = Reset && (r_state == S_IDLE);
    assign w_accept    = ChunkValid && ChunkReady;
    assign w_new_msg   = ChunkFirst || !r_chain_valid;
    assign w_mode_in   = Mode224 & ENABLE_224;
    assign DigestValid = r_digest_valid;
    assign Digest      = r_digest;
    assign Busy        = (r_state == S_HASH) || (r_state == S_FINAL);

    // Unrolled round chain; the message schedule slides so W[t] is always window slot 0.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so no latch is inferred.
        w_w_next  = r_w;
        w_wk_next = r_wk;
        w_t1      = '0;
        w_t2      = '0;
        w_sched   = '0;
        w_kidx    = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            w_kidx = r_cnt[5:0] + 6'(j);
            w_t1 = w_wk_next[7] + big_sigma1(w_wk_next[4])
                 + ((w_wk_next[4] & w_wk_next[5]) ^ (~w_wk_next[4] & w_wk_next[6]))
                 + K[w_kidx] + w_w_next[0];
            w_t2 = big_sigma0(w_wk_next[0])
                 + ((w_wk_next[0] & w_wk_next[1]) ^ (w_wk_next[0] & w_wk_next[2]) ^ (w_wk_next[1] & w_wk_next[2]));
            for (int i = 7; i > 0; i--) w_wk_next[i] = w_wk_next[i-1];
            w_wk_next[4] = w_wk_next[4] + w_t1;
            w_wk_next[0] = w_t1 + w_t2;
            w_sched = small_sigma1(w_w_next[14]) + w_w_next[9] + small_sigma0(w_w_next[1]) + w_w_next[0];
            for (int i = 0; i < 15; i++) w_w_next[i] = w_w_next[i+1];
            w_w_next[15] = w_sched;
        end
    end

    always_comb begin
        w_digest = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum[i] = r_h[i] + r_wk[i];
            w_iv[i]  = w_mode_in ? IV224[i] : IV256[i];
            w_digest[255 - 32*i -: 32] = w_sum[i];
        end
        if (r_mode) w_digest[31:0] = '0;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_HASH;
            S_HASH:  if (r_cnt == LAST_CNT) w_next = S_FINAL;
            S_FINAL: w_next = r_last ? S_DONE : S_IDLE;
            S_DONE:  if (DigestAck) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_cnt          <= '0;
            r_mode         <= 1'b0;
            r_last         <= 1'b0;
            r_chain_valid  <= 1'b0;
            r_digest_valid <= 1'b0;
            r_digest       <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt  <= '0;
                    r_last <= ChunkLast;
                    if (w_new_msg) r_mode <= w_mode_in;
                end
                S_HASH: r_cnt <= r_cnt + STEP;
                S_FINAL: begin
                    r_chain_valid <= 1'b1;
                    if (r_last) begin
                        r_digest       <= w_digest;
                        r_digest_valid <= 1'b1;
                    end
                end
                S_DONE: if (DigestAck) begin
                    r_digest_valid <= 1'b0;
                    r_chain_valid  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the schedule window and hash words are only read after a load, so they carry no reset.
    always_ff @(posedge Clk) begin
        case (r_state)
            S_IDLE: if (w_accept) begin
                for (int i = 0; i < 16; i++) r_w[i] <= Chunk[511 - 32*i -: 32];
                for (int i = 0; i < 8; i++) begin
                    if (w_new_msg) r_h[i] <= w_iv[i];
                    r_wk[i] <= w_new_msg ? w_iv[i] : r_h[i];
                end
            end
            S_HASH: begin
                r_w  <= w_w_next;
                r_wk <= w_wk_next;
            end
            S_FINAL: r_h <= w_sum;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sha256_stream.sv
// Scoreboard bench for sha256_stream: one R=1 and one R=4 instance exercised in turn with
// directed NIST vectors; a monitor pops expected digests/latencies when DigestValid rises.
module tb_sha256_stream;
    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO2 = {448'h0, 64'h1c0};
    localparam logic [255:0] D_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct packed {
        logic [255:0] digest;
        int           acc;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset, cvalid, cfirst, clast, cmode, ack, sel;
    logic [511:0] chunk;
    logic rdy0, rdy1, dv0, dv1, busy0, busy1;
    logic [255:0] dig0, dig1;
    logic ready_m, dv_m, busy_m;
    logic [255:0] dig_m;

    int   cyc = 0;
    int   lat = 66;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_stream #(.ROUNDS_PER_CYCLE(1), .ENABLE_224(1'b1)) dut_r1 (
        .Clk(clk), .Reset(reset), .ChunkValid(cvalid & ~sel), .ChunkReady(rdy0), .Chunk(chunk),
        .ChunkFirst(cfirst), .ChunkLast(clast), .Mode224(cmode), .DigestValid(dv0),
        .DigestAck(ack & ~sel), .Digest(dig0), .Busy(busy0)
    );
    sha256_stream #(.ROUNDS_PER_CYCLE(4), .ENABLE_224(1'b1)) dut_r4 (
        .Clk(clk), .Reset(reset), .ChunkValid(cvalid & sel), .ChunkReady(rdy1), .Chunk(chunk),
        .ChunkFirst(cfirst), .ChunkLast(clast), .Mode224(cmode), .DigestValid(dv1),
        .DigestAck(ack & sel), .Digest(dig1), .Busy(busy1)
    );

    assign ready_m = sel ? rdy1  : rdy0;
    assign dv_m    = sel ? dv1   : dv0;
    assign busy_m  = sel ? busy1 : busy0;
    assign dig_m   = sel ? dig1  : dig0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s (R=%0d): got %h expected %h", name, sel ? 4 : 1, act, exp_v);
        end
    endtask

    // Latency counts edges inclusively: the accept edge is edge 1, the edge raising DigestValid is edge N.
    always @(negedge clk) begin : monitor
        logic prev_dv;
        exp_t e;
        if (dv_m === 1'b1 && prev_dv !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_digest (R=%0d): got %h with nothing expected", sel ? 4 : 1, dig_m);
            end else begin
                e = exp_q.pop_front();
                check("digest", dig_m, e.digest);
                check("digest_latency", 256'(cyc - e.acc + 1), 256'(e.lat));
            end
        end
        prev_dv = dv_m;
    end

    task automatic send(input logic [511:0] blk, input bit first, input bit last, input bit m224,
                        input bit push, input logic [255:0] exp_d);
        int   budget;
        int   acc;
        exp_t e;
        @(negedge clk);
        chunk = blk; cfirst = first; clast = last; cmode = m224; cvalid = 1'b1;
        budget = 0;
        while (ready_m !== 1'b1 && budget < 200) begin @(negedge clk); budget++; end
        check("accept_ready", 256'(ready_m), 256'(1));
        acc = cyc + 1;
        if (push) begin
            e.digest = exp_d; e.acc = acc; e.lat = lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cvalid = 1'b0;
        if (!last) begin
            budget = 0;
            while (ready_m !== 1'b1 && budget < 200) begin @(negedge clk); budget++; end
            check("ready_latency", 256'(cyc - acc + 1), 256'(lat));
        end
    endtask

    // Waits for the digest, optionally holds it with a new chunk pending, then acknowledges.
    task automatic collect(input int hold, input bit pend);
        int           budget;
        logic [255:0] snap;
        exp_t         e;
        budget = 0;
        while (dv_m !== 1'b1 && budget < 200) begin @(negedge clk); budget++; end
        check("digest_valid_seen", 256'(dv_m), 256'(1));
        snap = dig_m;
        if (pend) begin
            chunk = ABC; cfirst = 1'b1; clast = 1'b1; cmode = 1'b0; cvalid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ready", 256'(ready_m), 256'(0));
            check("hold_valid", 256'(dv_m), 256'(1));
            check("hold_digest", dig_m, snap);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_valid_low", 256'(dv_m), 256'(0));
        check("ack_ready_high", 256'(ready_m), 256'(1));
        if (pend) begin
            e.digest = D_ABC256; e.acc = cyc + 1; e.lat = lat;
            exp_q.push_back(e);
            @(negedge clk);
            cvalid = 1'b0;
            collect(0, 1'b0);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(negedge clk);
        check("ready_in_reset", 256'(ready_m), 256'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_ready", 256'(ready_m), 256'(1));
        check("reset_valid", 256'(dv_m), 256'(0));
        check("reset_digest", dig_m, 256'h0);
        check("reset_busy", 256'(busy_m), 256'(0));
    endtask

    task automatic run_suite();
        apply_reset();
        // Single block SHA-256; an early ack during hashing must be ignored.
        send(ABC, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC256);
        check("busy_hash", 256'(busy_m), 256'(1));
        ack = 1'b1;
        repeat (5) @(negedge clk);
        ack = 1'b0;
        collect(0, 1'b0);
        // SHA-224 single block.
        send(ABC, 1'b1, 1'b1, 1'b1, 1'b1, D_ABC224);
        collect(0, 1'b0);
        // Two-block message; Mode224 on the second chunk is ignored.
        send(TWO1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        send(TWO2, 1'b0, 1'b1, 1'b1, 1'b1, D_TWO);
        collect(0, 1'b0);
        // A new first chunk mid-message discards the old chain.
        send(TWO1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        send(ABC, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC256);
        collect(0, 1'b0);
        // Backpressure on the digest with a chunk waiting.
        send(ABC, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC256);
        collect(100, 1'b1);
        // Reset mid-hash, then a First=0 chunk starts a fresh message.
        send(ABC, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        repeat (sel ? 7 : 29) @(negedge clk);
        apply_reset();
        repeat (80) @(negedge clk);
        check("no_stale_valid", 256'(dv_m), 256'(0));
        send(ABC, 1'b0, 1'b1, 1'b0, 1'b1, D_ABC256);
        collect(0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; cvalid = 1'b0; cfirst = 1'b0; clast = 1'b0; cmode = 1'b0;
        ack = 1'b0; sel = 1'b0; chunk = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            lat = (s == 0) ? 66 : 18;
            run_suite();
        end
        repeat (20) @(negedge clk);
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got %0d cycles expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
